spi_xfer_sequencer: RTL

Synthesizable Wishbone bus master that sequences complete SPI transfers on the SPI core's 5-bit register port. Accepts one transfer command at a time and programs DIVIDER (when changed), SS, TX0, then CTRL with GO set. It polls CTRL until GO clears, reads RX0 and returns the received word with an error flag. It replaces task-driven bench stimulus with real bus sequencing for system use.

---
 rtl/spi_pkg.sv | 37 +++
 rtl/wb_access_unit.sv | 73 +++++++
 rtl/spi_xfer_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI core register port and the transfer sequencer FSM.
package spi_pkg;

  // SPI core register addresses (5-bit Wishbone address space)
  localparam logic [4:0] ADR_RX0     = 5'h00;
  localparam logic [4:0] ADR_TX0     = 5'h00;
  localparam logic [4:0] ADR_CTRL    = 5'h10;
  localparam logic [4:0] ADR_DIVIDER = 5'h14;
  localparam logic [4:0] ADR_SS      = 5'h18;

  // CTRL register fields
  localparam int unsigned CTRL_GO_BIT  = 8;
  localparam int unsigned CTRL_ASS_BIT = 13;
  localparam int unsigned CTRL_LEN_W   = 7;

  // Bits owned by the sequencer; static flags may not override them
  localparam logic [31:0] CTRL_OWNED_MASK = 32'h0000_017F;

  typedef enum logic [3:0] {
    StIdle,
    StWrDiv,
    StWrSs,
    StWrTx,
    StWrCfg,
    StWrGo,
    StPoll,
    StRdRx,
    StResp
  } seq_state_e;

  // CTRL write value: static flags with CHAR_LEN and GO inserted
  function automatic logic [31:0] ctrl_word(logic [31:0] flags, logic [CTRL_LEN_W-1:0] len,
                                            logic go);
    ctrl_word = (flags & ~CTRL_OWNED_MASK) | {23'h0, go, 1'b0, len};
  endfunction

endpackage

// File: rtl/wb_access_unit.sv
// Single Wishbone read/write engine with ack timeout. One access per start pulse.
module wb_access_unit #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_i,
  input  logic [4:0]  adr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic [4:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam logic [15:0] TmoLast = 16'(ACK_TIMEOUT - 1);

  logic [4:0]  adr_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic        cyc_q;
  logic [15:0] tmo_q;
  logic        timeout;

  // Completion decode; slave responses only count while the cycle is open
  always_comb begin
    timeout = (tmo_q == TmoLast);
    done_o  = cyc_q & (wb_ack_i | wb_err_i | timeout);
    err_o   = cyc_q & (wb_err_i | (timeout & ~wb_ack_i));
    rdata_o = wb_dat_i;
  end

  // Bus output registers and per-access timeout counter
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      we_q  <= 1'b0;
      cyc_q <= 1'b0;
      tmo_q <= '0;
    end else if (start_i) begin
      adr_q <= adr_i;
      dat_q <= we_i ? wdata_i : 32'h0;
      sel_q <= 4'hF;
      we_q  <= we_i;
      cyc_q <= 1'b1;
      tmo_q <= '0;
    end else if (done_o) begin
      cyc_q <= 1'b0;
    end else if (cyc_q) begin
      tmo_q <= tmo_q + 16'd1;
    end
  end

  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;
  assign wb_we_o  = we_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Sequences a full SPI transfer (DIVIDER, SS, TX0, CTRL, GO, poll, RX0) over Wishbone.
module spi_xfer_sequencer
  import spi_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned POLL_LIMIT  = 1024,
  parameter logic [31:0] CTRL_FLAGS  = 32'h1 << CTRL_ASS_BIT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        cmd_valid_in,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_tx_in,
  input  logic [6:0]  cmd_len_in,
  input  logic [7:0]  cmd_ss_in,
  input  logic [15:0] cmd_div_in,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic [4:0]  adr_o,
  output logic [31:0] dat_o,
  output logic [3:0]  sel_o,
  output logic        we_o,
  output logic        cyc_o,
  output logic        stb_o,
  input  logic [31:0] dat_in,
  input  logic        ack_in,
  input  logic        err_in
);

  seq_state_e  state_q, state_d;
  logic [31:0] tx_q;
  logic [6:0]  len_q;
  logic [7:0]  ss_q;
  logic [15:0] div_q;
  logic [15:0] last_div_q, last_div_d;
  logic        div_valid_q, div_valid_d;
  logic [31:0] poll_cnt_q, poll_cnt_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_valid_q;
  logic        cmd_ready_q;
  logic        accept;

  logic        acc_start;
  logic [4:0]  acc_adr;
  logic [31:0] acc_wdata;
  logic        acc_we;
  logic        acc_done;
  logic        acc_err;
  logic [31:0] acc_rdata;

  // Launch an access in the idle cycle after entering any bus state
  assign acc_start = !cyc_o && (state_q inside {StWrDiv, StWrSs, StWrTx, StWrCfg, StWrGo,
                                                StPoll, StRdRx});

  wb_access_unit #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_access (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .start_i (acc_start),
    .adr_i   (acc_adr),
    .wdata_i (acc_wdata),
    .we_i    (acc_we),
    .done_o  (acc_done),
    .err_o   (acc_err),
    .rdata_o (acc_rdata),
    .wb_adr_o(adr_o),
    .wb_dat_o(dat_o),
    .wb_sel_o(sel_o),
    .wb_we_o (we_o),
    .wb_cyc_o(cyc_o),
    .wb_stb_o(stb_o),
    .wb_dat_i(dat_in),
    .wb_ack_i(ack_in),
    .wb_err_i(err_in)
  );

  // Next-state logic and per-state access request
  always_comb begin
    state_d     = state_q;
    last_div_d  = last_div_q;
    div_valid_d = div_valid_q;
    poll_cnt_d  = poll_cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    accept      = 1'b0;
    acc_adr     = ADR_RX0;
    acc_wdata   = '0;
    acc_we      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_in) begin
          accept     = 1'b1;
          poll_cnt_d = '0;
          state_d    = (!div_valid_q || (cmd_div_in != last_div_q)) ? StWrDiv : StWrSs;
        end
      end
      StWrDiv: begin
        acc_adr   = ADR_DIVIDER;
        acc_wdata = {16'h0, div_q};
        acc_we    = 1'b1;
        if (acc_done) begin
          last_div_d  = div_q;
          div_valid_d = 1'b1;
          state_d     = StWrSs;
        end
      end
      StWrSs: begin
        acc_adr   = ADR_SS;
        acc_wdata = {24'h0, ss_q};
        acc_we    = 1'b1;
        if (acc_done) state_d = StWrTx;
      end
      StWrTx: begin
        acc_adr   = ADR_TX0;
        acc_wdata = tx_q;
        acc_we    = 1'b1;
        if (acc_done) state_d = StWrCfg;
      end
      StWrCfg: begin
        acc_adr   = ADR_CTRL;
        acc_wdata = ctrl_word(CTRL_FLAGS, len_q, 1'b0);
        acc_we    = 1'b1;
        if (acc_done) state_d = StWrGo;
      end
      StWrGo: begin
        acc_adr   = ADR_CTRL;
        acc_wdata = ctrl_word(CTRL_FLAGS, len_q, 1'b1);
        acc_we    = 1'b1;
        if (acc_done) state_d = StPoll;
      end
      StPoll: begin
        acc_adr = ADR_CTRL;
        if (acc_done) begin
          poll_cnt_d = poll_cnt_q + 32'd1;
          if (!acc_rdata[CTRL_GO_BIT]) begin
            state_d = StRdRx;
          end else if (poll_cnt_d == POLL_LIMIT) begin
            state_d    = StResp;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end
        end
      end
      StRdRx: begin
        acc_adr = ADR_RX0;
        if (acc_done) begin
          rsp_data_d = acc_rdata;
          rsp_err_d  = 1'b0;
          state_d    = StResp;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Any failed access aborts the transfer; a lost DIVIDER write forces a rewrite
    if (acc_done && acc_err) begin
      state_d    = StResp;
      rsp_err_d  = 1'b1;
      rsp_data_d = '0;
      if (state_q == StWrDiv) div_valid_d = 1'b0;
    end
  end

  // State, latched command and registered response outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      tx_q        <= '0;
      len_q       <= '0;
      ss_q        <= '0;
      div_q       <= '0;
      last_div_q  <= '0;
      div_valid_q <= 1'b0;
      poll_cnt_q  <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      last_div_q  <= last_div_d;
      div_valid_q <= div_valid_d;
      poll_cnt_q  <= poll_cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= (state_d == StResp);
      cmd_ready_q <= (state_d == StIdle);
      if (accept) begin
        tx_q  <= cmd_tx_in;
        len_q <= cmd_len_in;
        ss_q  <= cmd_ss_in;
        div_q <= cmd_div_in;
      end
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
